floor_request_scheduler: RTL and testbench
==========================================

FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 10: number of served floors, 0..NUM_FLOORS-1, max 16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: button sample period in clk cycles.
REQ-003 Parameter DWELL_CYCLES, default 32: door-dwell duration in clk cycles.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 call_btn  input  NUM_FLOORS  asynchronous hall/car buttons, bit i = floor i, active-high.
REQ-007 current_floor  input  4  car position from the elevator controller.
REQ-008 car_idle  input  1  high when the elevator controller is in its idle state.
REQ-009 requested_floor  output  4  registered target floor driven to the elevator controller.
REQ-010 pending  output  NUM_FLOORS  registered outstanding-request bitmap.
REQ-011 dir_up  output  1  registered sweep direction, 1 = up.
REQ-012 door_open  output  1  registered, high exactly while in DWELL.

Function
REQ-013 Each call_btn bit SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A shared tick SHALL pulse one cycle every DEBOUNCE_CYCLES cycles; synchronized buttons are sampled only on the tick.
REQ-015 A press SHALL register when a bit samples 1 on a tick after sampling 0 on the previous tick; held buttons produce no further presses.
REQ-016 A registered press SHALL set pending[i] on the following cycle; already-set bits stay set.
REQ-017 States: IDLE, UP, DOWN, DWELL.
REQ-018 IDLE: pending[current_floor] set and car_idle -> DWELL; else any pending above current_floor -> UP; else any pending below -> DOWN; else stay.
REQ-019 UP: requested_floor SHALL be the lowest pending floor strictly above current_floor; dir_up=1.
REQ-020 DOWN: requested_floor SHALL be the highest pending floor strictly below current_floor; dir_up=0.
REQ-021 UP/DOWN: car_idle and pending[current_floor] set -> DWELL; no pending in sweep direction and none at current_floor -> opposite sweep if any pending there, else IDLE.
REQ-022 In IDLE and DWELL, requested_floor SHALL equal current_floor, so the controller holds position.
REQ-023 On DWELL entry pending[current_floor] SHALL clear; it SHALL stay held clear throughout DWELL, and clear wins over a simultaneous press of that floor.
REQ-024 A press on another floor during DWELL SHALL set its bit normally.
REQ-025 DWELL lasts exactly DWELL_CYCLES cycles, then: pending in dir_up direction -> same sweep; else pending opposite -> opposite sweep with dir_up flipped; else IDLE.
REQ-026 current_floor >= NUM_FLOORS SHALL match no pending bit; requested_floor then holds its previous value.
REQ-027 Target selection is combinational from pending and current_floor, registered once, giving 1-cycle latency from pending change to requested_floor.
REQ-028 All comparisons are unsigned 4-bit; the dwell counter SHALL never wrap.

Reset
REQ-029 While rst_n=0 at a clk edge: state IDLE, pending 0, requested_floor 0, dir_up 1, door_open 0, tick and dwell counters 0, synchronizer and sample flops 0.
REQ-030 Reset mid-sweep or mid-dwell SHALL discard all pending requests; no press SHALL register on the first tick after reset unless that button was sampled 0 and then 1.

Structure
REQ-031 Package floor_sched_pkg SHALL hold the state encoding and default NUM_FLOORS, DEBOUNCE_CYCLES, DWELL_CYCLES constants.
REQ-032 Sub-module btn_sync_edge, with a 2-flop synchronizer, tick-gated sampling and rising-edge pulse, SHALL be instantiated once per floor.
REQ-033 Output encoding stays compatible with the existing 4-bit floor bus and the 7-segment display path.

Verification
REQ-034 Reset, current_floor=0, car_idle=1, press floor 5 for 3 ticks -> pending=0x020, UP, requested_floor=5 one cycle after pending sets.
REQ-035 Car at 2 heading up, pending {1,4,7} -> requested_floor 4; at floor 4 with car_idle -> DWELL 32 cycles, bit 4 clears, then requested_floor 7; after 7 -> DOWN, requested_floor 1.
REQ-036 In DWELL at floor 3, hold button 3 continuously and press floor 6 -> bit 3 stays 0, bit 6 sets, exit to UP with requested_floor 6.
REQ-037 Button glitch high for fewer than DEBOUNCE_CYCLES cycles between ticks -> pending unchanged.
REQ-038 Assert rst_n=0 for one cycle mid-sweep with pending {0,9} -> next cycle pending=0, IDLE, requested_floor=0, dir_up=1.
REQ-039 Drive current_floor=12 with pending {3} -> no DWELL entry, requested_floor holds its prior value.

Source files
------------

// File: rtl/floor_sched_pkg.sv
// Shared types and default sizing for the floor request scheduler.
// The floor bus is fixed at 4 bits to match the existing controller and display path.
package floor_sched_pkg;

  localparam int DEF_NUM_FLOORS      = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_DWELL_CYCLES    = 32;
  localparam int FLOOR_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DWELL = 2'd3
  } sched_state_e;

  // Out-of-range car positions (e.g. 12 with 10 floors) match no request bit.
  function automatic logic floor_in_range(input logic [FLOOR_W-1:0] floor, input int num_floors);
    return ({1'b0, floor} < 5'(num_floors));
  endfunction

endpackage

// File: rtl/floor_request_scheduler_btn_sync_edge.sv
// One call button: 2-flop synchronizer, tick-gated sample and a one-cycle
// press pulse on a 0 -> 1 change between consecutive tick samples.
module btn_sync_edge
  import floor_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic sample_q;
  logic sample_d;
  logic press_q;
  logic press_d;

  // Sample only on the shared tick; held buttons never re-trigger.
  always_comb begin
    sample_d = sample_q;
    press_d  = 1'b0;
    if (tick_i) begin
      sample_d = sync2_q;
      press_d  = sync2_q & ~sample_q;
    end else begin
      sample_d = sample_q;
      press_d  = 1'b0;
    end
  end

  // Synchronizer, sample and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/floor_request_scheduler.sv
// Collects debounced floor calls into a pending bitmap and runs an up/down
// sweep scheduler that hands one target floor at a time to the car controller.
module floor_request_scheduler
  import floor_sched_pkg::*;
#(
  parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  car_idle,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam int TICK_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic [TICK_W-1:0]     tick_cnt_q;
  logic [TICK_W-1:0]     tick_cnt_d;
  logic                  tick_q;
  logic                  tick_last_s;
  logic [NUM_FLOORS-1:0] press_s;

  sched_state_e          state_q;
  sched_state_e          state_d;
  logic                  dir_up_q;
  logic                  dir_up_d;
  logic                  door_open_q;
  logic                  door_open_d;
  logic [3:0]            requested_q;
  logic [3:0]            requested_d;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [DWELL_W-1:0]    dwell_cnt_q;
  logic [DWELL_W-1:0]    dwell_cnt_d;

  logic                  floor_valid_s;
  logic [NUM_FLOORS-1:0] hit_s;
  logic [NUM_FLOORS-1:0] above_s;
  logic [NUM_FLOORS-1:0] below_s;
  logic [NUM_FLOORS-1:0] clr_s;
  logic                  any_above_s;
  logic                  any_below_s;
  logic                  at_floor_s;
  logic [3:0]            low_above_s;
  logic [3:0]            high_below_s;
  logic                  dwell_done_s;

  // Free-running debounce tick generator.
  always_comb begin
    tick_last_s = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = tick_last_s ? {TICK_W{1'b0}} : tick_cnt_q + 1'b1;
  end

  // Tick counter and registered tick pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= {TICK_W{1'b0}};
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_last_s;
    end
  end

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    btn_sync_edge u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick_q),
      .btn_i   (call_btn[g]),
      .press_o (press_s[g])
    );
  end

  // Classify pending floors relative to the car and pick the nearest in each direction.
  always_comb begin
    floor_valid_s = floor_in_range(current_floor, NUM_FLOORS);
    hit_s         = {NUM_FLOORS{1'b0}};
    above_s       = {NUM_FLOORS{1'b0}};
    below_s       = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      hit_s[i]   = floor_valid_s & (4'(i) == current_floor);
      above_s[i] = floor_valid_s & pending_q[i] & (4'(i) > current_floor);
      below_s[i] = floor_valid_s & pending_q[i] & (4'(i) < current_floor);
    end
    any_above_s = |above_s;
    any_below_s = |below_s;
    at_floor_s  = |(hit_s & pending_q);
    low_above_s = current_floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      low_above_s = above_s[i] ? 4'(i) : low_above_s;
    end
    high_below_s = current_floor;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      high_below_s = below_s[i] ? 4'(i) : high_below_s;
    end
  end

  // Sweep scheduler next-state; an unknown car position freezes the sweep.
  always_comb begin
    state_d      = state_q;
    dir_up_d     = dir_up_q;
    dwell_done_s = (dwell_cnt_q == DWELL_LAST);
    case (state_q)
      ST_IDLE: begin
        if (at_floor_s && car_idle) begin
          state_d = ST_DWELL;
        end else if (any_above_s) begin
          state_d  = ST_UP;
          dir_up_d = 1'b1;
        end else if (any_below_s) begin
          state_d  = ST_DOWN;
          dir_up_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UP: begin
        if (!floor_valid_s) begin
          state_d = ST_UP;
        end else if (car_idle && at_floor_s) begin
          state_d = ST_DWELL;
        end else if (!any_above_s && !at_floor_s) begin
          if (any_below_s) begin
            state_d  = ST_DOWN;
            dir_up_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_UP;
        end
      end
      ST_DOWN: begin
        if (!floor_valid_s) begin
          state_d = ST_DOWN;
        end else if (car_idle && at_floor_s) begin
          state_d = ST_DWELL;
        end else if (!any_below_s && !at_floor_s) begin
          if (any_above_s) begin
            state_d  = ST_UP;
            dir_up_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DOWN;
        end
      end
      ST_DWELL: begin
        if (!dwell_done_s) begin
          state_d = ST_DWELL;
        end else if (dir_up_q && any_above_s) begin
          state_d = ST_UP;
        end else if (!dir_up_q && any_below_s) begin
          state_d = ST_DOWN;
        end else if (any_below_s) begin
          state_d  = ST_DOWN;
          dir_up_d = 1'b0;
        end else if (any_above_s) begin
          state_d  = ST_UP;
          dir_up_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        dir_up_d = 1'b1;
      end
    endcase
  end

  // Datapath next values derived from the chosen next state.
  always_comb begin
    dwell_cnt_d = ((state_q == ST_DWELL) && (state_d == ST_DWELL)) ?
                  dwell_cnt_q + 1'b1 : {DWELL_W{1'b0}};
    door_open_d = (state_d == ST_DWELL);
    // Clearing the car's floor outranks a press landing in the same cycle.
    clr_s       = hit_s & {NUM_FLOORS{state_d == ST_DWELL}};
    pending_d   = (pending_q | press_s) & ~clr_s;
    if (!floor_valid_s) begin
      requested_d = requested_q;
    end else if ((state_d == ST_UP) && any_above_s) begin
      requested_d = low_above_s;
    end else if ((state_d == ST_DOWN) && any_below_s) begin
      requested_d = high_below_s;
    end else begin
      requested_d = current_floor;
    end
  end

  // Scheduler state and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_up_q    <= 1'b1;
      door_open_q <= 1'b0;
      requested_q <= 4'd0;
      pending_q   <= {NUM_FLOORS{1'b0}};
      dwell_cnt_q <= {DWELL_W{1'b0}};
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      door_open_q <= door_open_d;
      requested_q <= requested_d;
      pending_q   <= pending_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign requested_floor = requested_q;
  assign pending         = pending_q;
  assign dir_up          = dir_up_q;
  assign door_open       = door_open_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Self-checking bench: table vectors, directed corner sequences and random
// stimulus compared every cycle against a cycle-timed behavioural model.
module tb_floor_request_scheduler;

  localparam int NF = 10;
  localparam int DB = 16;
  localparam int DW = 32;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_DWELL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] call_btn = '0;
  logic [3:0]    current_floor = 4'd0;
  logic          car_idle = 1'b0;
  logic [3:0]    requested_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  floor_request_scheduler #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .call_btn(call_btn), .current_floor(current_floor),
    .car_idle(car_idle), .requested_floor(requested_floor), .pending(pending),
    .dir_up(dir_up), .door_open(door_open)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int lowest_above(input logic [NF-1:0] p, input logic [3:0] f);
    if (int'(f) >= NF) return -1;
    for (int i = int'(f) + 1; i < NF; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int highest_below(input logic [NF-1:0] p, input logic [3:0] f);
    if (int'(f) >= NF) return -1;
    for (int i = int'(f) - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  int            m_cyc = 0;
  int            m_state = M_IDLE;
  int            m_dwell_end = 0;
  bit            m_dir = 1'b1;
  bit            m_door = 1'b0;
  logic [3:0]    m_req = 4'd0;
  logic [NF-1:0] m_pend = '0;
  logic [NF-1:0] m_press = '0;
  logic [NF-1:0] m_last = '0;
  logic [NF-1:0] m_h1 = '0;
  logic [NF-1:0] m_h2 = '0;

  always @(posedge clk) begin : model_blk
    int la, hb, ns;
    bit at, valid, nd;
    logic [NF-1:0] np;
    if (!rst_n) begin
      m_cyc = 0; m_state = M_IDLE; m_dir = 1'b1; m_door = 1'b0; m_req = 4'd0;
      m_pend = '0; m_press = '0; m_last = '0; m_h1 = '0; m_h2 = '0;
    end else begin
      m_cyc++;
      valid = (int'(current_floor) < NF);
      la = lowest_above(m_pend, current_floor);
      hb = highest_below(m_pend, current_floor);
      at = valid && m_pend[current_floor];
      ns = m_state; nd = m_dir;
      case (m_state)
        M_IDLE:
          if (at && car_idle) ns = M_DWELL;
          else if (la >= 0) begin ns = M_UP; nd = 1'b1; end
          else if (hb >= 0) begin ns = M_DOWN; nd = 1'b0; end
        M_UP:
          if (valid) begin
            if (car_idle && at) ns = M_DWELL;
            else if (la < 0 && !at) begin
              if (hb >= 0) begin ns = M_DOWN; nd = 1'b0; end else ns = M_IDLE;
            end
          end
        M_DOWN:
          if (valid) begin
            if (car_idle && at) ns = M_DWELL;
            else if (hb < 0 && !at) begin
              if (la >= 0) begin ns = M_UP; nd = 1'b1; end else ns = M_IDLE;
            end
          end
        default:
          if (m_cyc == m_dwell_end) begin
            if (m_dir && la >= 0) ns = M_UP;
            else if (!m_dir && hb >= 0) ns = M_DOWN;
            else if (hb >= 0) begin ns = M_DOWN; nd = 1'b0; end
            else if (la >= 0) begin ns = M_UP; nd = 1'b1; end
            else ns = M_IDLE;
          end
      endcase
      if (ns == M_DWELL && m_state != M_DWELL) m_dwell_end = m_cyc + DW;
      if (valid) begin
        if (ns == M_UP && la >= 0) m_req = 4'(la);
        else if (ns == M_DOWN && hb >= 0) m_req = 4'(hb);
        else m_req = current_floor;
      end
      np = m_pend | m_press;
      if (ns == M_DWELL && valid) np[current_floor] = 1'b0;
      // Buttons are sampled one edge after every DB-th edge, seeing the level from 2 edges back.
      if (m_cyc > 1 && ((m_cyc - 1) % DB) == 0) begin
        m_press = m_h2 & ~m_last;
        m_last  = m_h2;
      end else begin
        m_press = '0;
      end
      m_h2 = m_h1;
      m_h1 = call_btn;
      m_pend = np; m_state = ns; m_dir = nd; m_door = (ns == M_DWELL);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req", requested_floor, m_req);
      check("model_pend", pending, m_pend);
      check("model_dir", dir_up, m_dir);
      check("model_door", door_open, m_door);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    call_btn = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pending(input logic [NF-1:0] mask, input int budget);
    int n;
    n = 0;
    while (pending !== mask && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pend_settle", pending, mask);
  endtask

  typedef struct {
    logic [NF-1:0] mask;
    logic [3:0]    cf;
    logic          idle;
    logic [3:0]    exp_req;
    logic          exp_dir;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dcnt;
    int idx;
    vecs[0] = '{10'h092, 4'd2,  1'b0, 4'd4, 1'b1};
    vecs[1] = '{10'h009, 4'd6,  1'b0, 4'd3, 1'b0};
    vecs[2] = '{10'h200, 4'd0,  1'b0, 4'd9, 1'b1};
    vecs[3] = '{10'h001, 4'd9,  1'b0, 4'd0, 1'b0};
    vecs[4] = '{10'h104, 4'd5,  1'b0, 4'd8, 1'b1};
    vecs[5] = '{10'h010, 4'd4,  1'b0, 4'd4, 1'b1};
    vecs[6] = '{10'h008, 4'd12, 1'b0, 4'd0, 1'b1};

    do_reset();
    chk_en = 1'b1;
    check("rst_pend", pending, 0);
    check("rst_req", requested_floor, 0);
    check("rst_dir", dir_up, 1);
    check("rst_door", door_open, 0);

    // Table-driven target selection from a settled pending set.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      current_floor = vecs[v].cf;
      car_idle = vecs[v].idle;
      call_btn = vecs[v].mask;
      wait_pending(vecs[v].mask, 80);
      call_btn = '0;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_req", v), requested_floor, vecs[v].exp_req);
      check($sformatf("vec%0d_dir", v), dir_up, vecs[v].exp_dir);
    end

    // Single press from floor 0: one cycle from pending to requested_floor.
    do_reset();
    current_floor = 4'd0; car_idle = 1'b1;
    call_btn = 10'h020;
    wait_pending(10'h020, 80);
    check("lat_req_before", requested_floor, 0);
    @(negedge clk);
    check("lat_req_after", requested_floor, 5);
    check("lat_pend", pending, 10'h020);
    check("lat_dir", dir_up, 1);
    repeat (2 * DB) @(negedge clk);
    call_btn = '0;

    // Up sweep through 4 and 7, then reverse down to 1.
    do_reset();
    current_floor = 4'd2; car_idle = 1'b0;
    call_btn = 10'h092;
    wait_pending(10'h092, 80);
    call_btn = '0;
    @(negedge clk);
    check("sweep_req4", requested_floor, 4);
    current_floor = 4'd4; car_idle = 1'b1;
    @(negedge clk);
    check("dwell4_door", door_open, 1);
    check("dwell4_pend", pending, 10'h082);
    dcnt = 1;
    repeat (44) begin
      @(negedge clk);
      if (door_open) dcnt++;
    end
    check("dwell_len", dcnt, DW);
    check("sweep_req7", requested_floor, 7);
    check("sweep_dir_up", dir_up, 1);
    current_floor = 4'd7;
    repeat (40) @(negedge clk);
    check("sweep_req1", requested_floor, 1);
    check("sweep_dir_down", dir_up, 0);
    check("sweep_pend1", pending, 10'h002);

    // Held button at the dwell floor stays cleared; another floor's press lands.
    do_reset();
    current_floor = 4'd3; car_idle = 1'b1;
    call_btn = 10'h008;
    dcnt = 0;
    while (!door_open && dcnt < 80) begin
      @(negedge clk);
      dcnt++;
    end
    check("dwell3_enter", door_open, 1);
    call_btn = 10'h048;
    repeat (24) @(negedge clk);
    check("dwell3_door_held", door_open, 1);
    check("dwell3_bit3", pending[3], 0);
    check("dwell3_bit6", pending[6], 1);
    repeat (12) @(negedge clk);
    check("dwell3_exit_door", door_open, 0);
    check("dwell3_exit_req", requested_floor, 6);
    check("dwell3_exit_dir", dir_up, 1);
    call_btn = '0;

    // A glitch confined between two samples registers nothing.
    do_reset();
    current_floor = 4'd0; car_idle = 1'b0;
    dcnt = 0;
    while ((m_cyc % DB) != 2 && dcnt < 40) begin
      @(negedge clk);
      dcnt++;
    end
    call_btn = 10'h004;
    repeat (DB - 4) @(negedge clk);
    call_btn = '0;
    repeat (3 * DB) @(negedge clk);
    check("glitch_pend", pending, 0);

    // One-cycle reset mid-sweep discards everything.
    do_reset();
    current_floor = 4'd5; car_idle = 1'b0;
    call_btn = 10'h201;
    wait_pending(10'h201, 80);
    call_btn = '0;
    repeat (3) @(negedge clk);
    check("midrst_req_before", requested_floor, 9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_pend", pending, 0);
    check("midrst_req", requested_floor, 0);
    check("midrst_dir", dir_up, 1);
    check("midrst_door", door_open, 0);

    // Out-of-range position: no dwell, target holds its last value.
    do_reset();
    current_floor = 4'd2; car_idle = 1'b1;
    repeat (2) @(negedge clk);
    check("oor_req_before", requested_floor, 2);
    current_floor = 4'd12;
    call_btn = 10'h008;
    wait_pending(10'h008, 80);
    call_btn = '0;
    repeat (5) @(negedge clk);
    check("oor_req_hold", requested_floor, 2);
    check("oor_door", door_open, 0);

    // Random traffic, checked every cycle by the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, NF - 1);
        call_btn[idx] = ~call_btn[idx];
      end
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 9) == 0) current_floor = 4'($urandom_range(10, 15));
        else current_floor = 4'($urandom_range(0, NF - 1));
      end
      if ($urandom_range(0, 15) == 0) car_idle = ($urandom_range(0, 3) != 0);
      if (c == 2000) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
